guess_entry: RTL and testbench

Upstream stage of the 1A2B game core. Collects a four-digit guess one keypad digit at a time, rejects out-of-range and repeated digits, and supports backspace and clear. On submit it waits for the core to be ready, then presents the guess on stable `out_ans0..3` with a one-cycle `out_enter` pulse that drives the core's `in_enter`.

---
 rtl/guess_entry.sv | 151 +++++++++++++++
 tb/tb_guess_entry.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/guess_entry.sv
// Keypad entry stage for the 1A2B core: builds a four-digit guess with
// range/duplicate checks, backspace and clear, then hands it to the core.
module guess_entry #(
  parameter int unsigned DIGIT_MAX    = 9,
  parameter int unsigned ALLOW_REPEAT = 0
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_clear,
  input  logic [3:0] in_digit,
  input  logic       in_digit_valid,
  input  logic       in_backspace,
  input  logic       in_submit,
  input  logic       in_core_ready,
  output logic [3:0] out_ans0,
  output logic [3:0] out_ans1,
  output logic [3:0] out_ans2,
  output logic [3:0] out_ans3,
  output logic       out_enter,
  output logic [2:0] out_count,
  output logic [1:0] out_err,
  output logic       out_busy,
  output logic [1:0] out_state
);

  // Handshake: a completed guess is offered only while in_core_ready is high;
  // out_enter is a single-cycle pulse and out_ans* are stable from that cycle
  // until the next pulse, so the core may sample them on out_enter alone.
  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    WAIT_RDY = 2'd1,
    FIRE     = 2'd2
  } state_t;

  localparam logic [3:0] DMAX = 4'(DIGIT_MAX);
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_DUP   = 2'd2;
  localparam logic [1:0] ERR_LEN   = 2'd3;

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [1:0] err_q, err_d;
  logic [3:0] buf_q [4];
  logic [3:0] buf_d [4];
  logic [3:0] ans_q [4];
  logic       load_ans;
  logic       dup;

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < count_q) && (buf_q[i] == in_digit)) dup = 1'b1;
    end
    if (ALLOW_REPEAT != 0) dup = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_d    = err_q;
    buf_d    = buf_q;
    load_ans = 1'b0;
    case (state_q)
      COLLECT: begin
        if (in_clear) begin
          count_d = 3'd0;
          err_d   = ERR_NONE;
        end else if (in_submit) begin
          if (count_q != 3'd4) begin
            err_d = ERR_LEN;
          end else if (in_core_ready) begin
            state_d  = FIRE;
            load_ans = 1'b1;
            count_d  = 3'd0;
            err_d    = ERR_NONE;
          end else begin
            state_d = WAIT_RDY;
          end
        end else if (in_backspace) begin
          // Backspace on an empty buffer is a silent no-op.
          if (count_q != 3'd0) begin
            count_d = count_q - 3'd1;
            err_d   = ERR_NONE;
          end
        end else if (in_digit_valid) begin
          if (count_q == 3'd4)     err_d = ERR_LEN;
          else if (in_digit > DMAX) err_d = ERR_RANGE;
          else if (dup)             err_d = ERR_DUP;
          else begin
            buf_d[count_q[1:0]] = in_digit;
            count_d             = count_q + 3'd1;
            err_d               = ERR_NONE;
          end
        end
      end
      WAIT_RDY: begin
        if (in_clear) begin
          state_d = COLLECT;
          count_d = 3'd0;
          err_d   = ERR_NONE;
        end else if (in_core_ready) begin
          state_d  = FIRE;
          load_ans = 1'b1;
          count_d  = 3'd0;
          err_d    = ERR_NONE;
        end
      end
      FIRE: begin
        // Buffer was emptied on entry, so every strobe here is dropped.
        state_d = COLLECT;
        count_d = 3'd0;
      end
      default: begin
        state_d = COLLECT;
        count_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= COLLECT;
      count_q <= 3'd0;
      err_q   <= ERR_NONE;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= 4'd0;
        ans_q[i] <= 4'd0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= buf_d[i];
        if (load_ans) ans_q[i] <= buf_q[i];
      end
    end
  end

  assign out_ans0  = ans_q[0];
  assign out_ans1  = ans_q[1];
  assign out_ans2  = ans_q[2];
  assign out_ans3  = ans_q[3];
  assign out_enter = (state_q == FIRE);
  assign out_busy  = (state_q != COLLECT);
  assign out_count = count_q;
  assign out_err   = err_q;
  assign out_state = state_q;

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry: a vector table for single-cycle behaviour
// plus hand-written sequences for WAIT_RDY, clear-abort and reset-abort.
module tb_guess_entry;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [3:0] digit;
  logic       digit_valid;
  logic       backspace;
  logic       submit;
  logic       core_ready;
  logic [3:0] ans0, ans1, ans2, ans3;
  logic       enter;
  logic [2:0] count;
  logic [1:0] err;
  logic       busy;
  logic [1:0] state;

  int n_cmp;
  int n_err;

  guess_entry dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_clear      (clear),
    .in_digit      (digit),
    .in_digit_valid(digit_valid),
    .in_backspace  (backspace),
    .in_submit     (submit),
    .in_core_ready (core_ready),
    .out_ans0      (ans0),
    .out_ans1      (ans1),
    .out_ans2      (ans2),
    .out_ans3      (ans3),
    .out_enter     (enter),
    .out_count     (count),
    .out_err       (err),
    .out_busy      (busy),
    .out_state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        clr;
    logic [3:0]  dig;
    logic        dv;
    logic        bs;
    logic        sub;
    logic        rdy;
    logic [2:0]  exp_count;
    logic [1:0]  exp_err;
    logic        exp_enter;
    logic        exp_busy;
    logic [15:0] exp_ans;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t mk(logic c, logic [3:0] d, logic dv_, logic b, logic s,
                              logic r, logic [2:0] ec, logic [1:0] ee, logic en,
                              logic bz, logic [15:0] ea);
    vec_t v;
    v.clr = c; v.dig = d; v.dv = dv_; v.bs = b; v.sub = s; v.rdy = r;
    v.exp_count = ec; v.exp_err = ee; v.exp_enter = en; v.exp_busy = bz;
    v.exp_ans = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: present one cycle of inputs, then settle after the edge
  task automatic apply(input logic c, input logic [3:0] d, input logic dv_,
                       input logic b, input logic s, input logic r);
    clear = c; digit = d; digit_valid = dv_; backspace = b; submit = s; core_ready = r;
    @(posedge clk);
    #1;
    clear = 1'b0; digit_valid = 1'b0; backspace = 1'b0; submit = 1'b0;
  endtask

  task automatic key(input logic [3:0] d, input logic r);
    apply(1'b0, d, 1'b1, 1'b0, 1'b0, r);
  endtask

  function automatic logic [15:0] ans_word();
    return {ans0, ans1, ans2, ans3};
  endfunction

  task automatic check_status(input string tag, input logic [2:0] ec, input logic [1:0] ee,
                              input logic en, input logic bz, input logic [15:0] ea);
    check({tag, ".count"}, 32'(count), 32'(ec));
    check({tag, ".err"},   32'(err),   32'(ee));
    check({tag, ".enter"}, 32'(enter), 32'(en));
    check({tag, ".busy"},  32'(busy),  32'(bz));
    check({tag, ".ans"},   32'(ans_word()), 32'(ea));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear = 1'b0; digit = 4'd0; digit_valid = 1'b0; backspace = 1'b0;
    submit = 1'b0; core_ready = 1'b1;

    //           clr  dig  dv  bs  sub rdy  cnt err ent bsy ans
    vecs[0]  = mk(0, 4'd2, 1, 0, 0, 1, 3'd1, 2'd0, 0, 0, 16'h0000);
    vecs[1]  = mk(0, 4'd3, 1, 0, 0, 1, 3'd2, 2'd0, 0, 0, 16'h0000);
    vecs[2]  = mk(0, 4'd4, 1, 0, 0, 1, 3'd3, 2'd0, 0, 0, 16'h0000);
    vecs[3]  = mk(0, 4'd5, 1, 0, 0, 1, 3'd4, 2'd0, 0, 0, 16'h0000);
    vecs[4]  = mk(0, 4'd0, 0, 0, 1, 1, 3'd0, 2'd0, 1, 1, 16'h2345);
    vecs[5]  = mk(0, 4'd0, 0, 0, 0, 1, 3'd0, 2'd0, 0, 0, 16'h2345);
    vecs[6]  = mk(0, 4'd5, 1, 0, 0, 1, 3'd1, 2'd0, 0, 0, 16'h2345);
    vecs[7]  = mk(0, 4'd4, 1, 0, 0, 1, 3'd2, 2'd0, 0, 0, 16'h2345);
    vecs[8]  = mk(0, 4'd5, 1, 0, 0, 1, 3'd2, 2'd2, 0, 0, 16'h2345);
    vecs[9]  = mk(0, 4'd3, 1, 0, 0, 1, 3'd3, 2'd0, 0, 0, 16'h2345);
    vecs[10] = mk(0, 4'd12, 1, 0, 0, 1, 3'd3, 2'd1, 0, 0, 16'h2345);
    vecs[11] = mk(1, 4'd0, 0, 0, 0, 1, 3'd0, 2'd0, 0, 0, 16'h2345);
    vecs[12] = mk(0, 4'd5, 1, 0, 0, 1, 3'd1, 2'd0, 0, 0, 16'h2345);
    vecs[13] = mk(0, 4'd4, 1, 0, 0, 1, 3'd2, 2'd0, 0, 0, 16'h2345);
    vecs[14] = mk(0, 4'd2, 1, 0, 0, 1, 3'd3, 2'd0, 0, 0, 16'h2345);
    vecs[15] = mk(0, 4'd0, 0, 0, 1, 1, 3'd3, 2'd3, 0, 0, 16'h2345);
    vecs[16] = mk(0, 4'd8, 1, 0, 0, 1, 3'd4, 2'd0, 0, 0, 16'h2345);
    vecs[17] = mk(0, 4'd1, 1, 0, 0, 1, 3'd4, 2'd3, 0, 0, 16'h2345);
    vecs[18] = mk(0, 4'd0, 0, 1, 0, 1, 3'd3, 2'd0, 0, 0, 16'h2345);
    vecs[19] = mk(0, 4'd9, 1, 0, 0, 1, 3'd4, 2'd0, 0, 0, 16'h2345);
    vecs[20] = mk(0, 4'd0, 0, 0, 1, 1, 3'd0, 2'd0, 1, 1, 16'h5429);
    vecs[21] = mk(0, 4'd7, 1, 0, 0, 1, 3'd0, 2'd0, 0, 0, 16'h5429);
    vecs[22] = mk(0, 4'd7, 1, 0, 0, 1, 3'd1, 2'd0, 0, 0, 16'h5429);
    vecs[23] = mk(1, 4'd3, 1, 0, 0, 1, 3'd0, 2'd0, 0, 0, 16'h5429);
    vecs[24] = mk(0, 4'd0, 0, 1, 0, 1, 3'd0, 2'd0, 0, 0, 16'h5429);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_status("reset", 3'd0, 2'd0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      apply(vecs[i].clr, vecs[i].dig, vecs[i].dv, vecs[i].bs, vecs[i].sub, vecs[i].rdy);
      check_status($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_err,
                   vecs[i].exp_enter, vecs[i].exp_busy, vecs[i].exp_ans);
    end

    // WAIT_RDY: 5,4,2,3, backspace, 8, submit while core not ready
    key(4'd5, 1'b0); key(4'd4, 1'b0); key(4'd2, 1'b0); key(4'd3, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    key(4'd8, 1'b0);
    check_status("pre_wait", 3'd4, 2'd0, 1'b0, 1'b0, 16'h5429);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check_status($sformatf("wait%0d", k), 3'd4, 2'd0, 1'b0, 1'b1, 16'h5429);
      if (k == 2) key(4'd1, 1'b0);
      else apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_status("wait_end", 3'd4, 2'd0, 1'b0, 1'b1, 16'h5429);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("wait_fire", 3'd0, 2'd0, 1'b1, 1'b1, 16'h5428);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("wait_after", 3'd0, 2'd0, 1'b0, 1'b0, 16'h5428);

    // clear aborts a pending submit
    key(4'd1, 1'b0); key(4'd2, 1'b0); key(4'd3, 1'b0); key(4'd4, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_status("abort_wait", 3'd4, 2'd0, 1'b0, 1'b1, 16'h5428);
    apply(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("abort_clr", 3'd0, 2'd0, 1'b0, 1'b0, 16'h5428);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("abort_idle", 3'd0, 2'd0, 1'b0, 1'b0, 16'h5428);

    // asynchronous reset while waiting
    key(4'd6, 1'b0); key(4'd7, 1'b0); key(4'd8, 1'b0); key(4'd9, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_status("rst_wait", 3'd4, 2'd0, 1'b0, 1'b1, 16'h5428);
    core_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_status("rst_async", 3'd0, 2'd0, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    check_status("rst_hold", 3'd0, 2'd0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;
    key(4'd1, 1'b1); key(4'd2, 1'b1); key(4'd3, 1'b1); key(4'd0, 1'b1);
    check_status("post_rst_entry", 3'd4, 2'd0, 1'b0, 1'b0, 16'h0000);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_status("post_rst_fire", 3'd0, 2'd0, 1'b1, 1'b1, 16'h1230);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("post_rst_after", 3'd0, 2'd0, 1'b0, 1'b0, 16'h1230);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
